// File: rtl/fir_ram_arbiter.sv
// Single-port RAM arbiter between the AXI-Lite cfg path and the FIR engine.
// Optional performance counters are built only when FIR_ARB_PERF_EN is defined.
module fir_ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              cfg_req,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_gnt,
    output logic              cfg_rvalid,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              eng_busy,
    output logic [3:0]        ram_we,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              starve_o,
    output logic [15:0]       cfg_gnt_cnt,
    output logic [15:0]       eng_gnt_cnt,
    output logic [15:0]       conflict_cnt
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic       rr_ptr;     // 0: cfg wins the next idle-mode conflict, 1: eng
    logic [7:0] wait_cnt;
    logic       rd_cfg;
    logic       rd_eng;
    logic       starve_q;
    logic       both;
    logic       pick_cfg;
    logic       pick_eng;
    logic       forced;

    assign both = cfg_req && eng_req;

    always_comb begin
        pick_cfg = 1'b0;
        pick_eng = 1'b0;
        if (axis_rst_n) begin
            if (both) begin
                if (eng_busy) pick_cfg = (wait_cnt == LIM);
                else          pick_cfg = !rr_ptr;
                pick_eng = !pick_cfg;
            end else begin
                pick_cfg = cfg_req;
                pick_eng = eng_req;
            end
        end
    end

    assign forced  = pick_cfg && both && eng_busy;
    assign cfg_gnt = pick_cfg;
    assign eng_gnt = pick_eng;

    always_comb begin
        ram_we   = 4'h0;
        ram_en   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (pick_cfg) begin
            ram_addr = cfg_addr;
            ram_di   = cfg_wdata;
            if (cfg_we) ram_we = 4'hF;
            else        ram_en = 1'b1;
        end else if (pick_eng) begin
            ram_addr = eng_addr;
            ram_di   = eng_wdata;
            if (eng_we) ram_we = 4'hF;
            else        ram_en = 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            rr_ptr   <= 1'b0;
            wait_cnt <= 8'd0;
            rd_cfg   <= 1'b0;
            rd_eng   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            if (both) rr_ptr <= pick_cfg;
            if (cfg_req && !pick_cfg && eng_busy)
                wait_cnt <= (wait_cnt == LIM) ? wait_cnt : wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
            rd_cfg   <= pick_cfg && !cfg_we;
            rd_eng   <= pick_eng && !eng_we;
            starve_q <= forced;
        end
    end

    // Read tags are masked while reset is held so no response leaks out.
    assign cfg_rvalid = rd_cfg && axis_rst_n;
    assign eng_rvalid = rd_eng && axis_rst_n;
    assign cfg_rdata  = cfg_rvalid ? ram_do : '0;
    assign eng_rdata  = eng_rvalid ? ram_do : '0;
    assign starve_o   = starve_q;

`ifdef FIR_ARB_PERF_EN
    logic [15:0] cfg_cnt_q;
    logic [15:0] eng_cnt_q;
    logic [15:0] cnf_cnt_q;

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            cfg_cnt_q <= 16'd0;
            eng_cnt_q <= 16'd0;
            cnf_cnt_q <= 16'd0;
        end else begin
            if (pick_cfg && cfg_cnt_q != 16'hFFFF) cfg_cnt_q <= cfg_cnt_q + 16'd1;
            if (pick_eng && eng_cnt_q != 16'hFFFF) eng_cnt_q <= eng_cnt_q + 16'd1;
            if (both && cnf_cnt_q != 16'hFFFF)     cnf_cnt_q <= cnf_cnt_q + 16'd1;
        end
    end

    assign cfg_gnt_cnt  = cfg_cnt_q;
    assign eng_gnt_cnt  = eng_cnt_q;
    assign conflict_cnt = cnf_cnt_q;
`else
    assign cfg_gnt_cnt  = 16'd0;
    assign eng_gnt_cnt  = 16'd0;
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: doc/fir_ram_arbiter.md
Name: fir_ram_arbiter

Overview:
- Arbitrates one single-port 32-bit coefficient/data RAM (bram11-style, 1-cycle registered read) between two requesters.
- The AXI-Lite configuration path (cfg) and the FIR compute engine (eng) are the requesters.
- Sits inside the user project between the FIR core's RAM-port interface and the bram11 instance.
- Gives the engine priority while it is computing, bounds cfg starvation, and round-robins when the engine is idle.

Parameters:
- ADDR_W, 12, RAM address width (byte address, passed through unchanged).
- DATA_W, 32, RAM data width.
- STARVE_LIM, 8, max consecutive cycles cfg may wait while eng_busy=1 before a forced cfg grant; legal range 1..255.

Ports:
- axis_clk  in  1  clock for all logic.
- axis_rst_n  in  1  synchronous active-low reset.
- cfg_req  in  1  cfg access request, held until granted.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  ADDR_W  cfg address.
- cfg_wdata  in  DATA_W  cfg write data.
- cfg_gnt  out  1  cfg access issued to RAM this cycle.
- cfg_rvalid  out  1  cfg read data valid.
- cfg_rdata  out  DATA_W  cfg read data.
- eng_req, eng_we, eng_addr, eng_wdata  in  1/1/ADDR_W/DATA_W  engine request, same semantics as the cfg equivalents.
- eng_gnt, eng_rvalid, eng_rdata  out  1/1/DATA_W  engine grant and read response.
- eng_busy  in  1  engine computing (ap_start..ap_done); selects priority mode.
- ram_we  out  4  byte write enables.
- ram_en  out  1  read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_di  out  DATA_W  RAM write data.
- ram_do  in  DATA_W  RAM read data, valid the cycle after ram_en.
- starve_o  out  1  one-cycle pulse, cycle after a forced cfg grant.
- cfg_gnt_cnt, eng_gnt_cnt, conflict_cnt  out  16 each  performance counters (see Optional Feature).

Behaviour:
- Clock and reset: single clock axis_clk. Reset is synchronous, active-low on axis_rst_n.
- Reset values: every flop clears (rr_ptr=0 meaning cfg next, wait_cnt=0, rd tags=0, starve_o=0, counters=0).
- Outputs during reset: while axis_rst_n=0, cfg_gnt, eng_gnt, ram_we, ram_en, cfg_rvalid and eng_rvalid are forced to 0, even though the grants are combinational.
- Grant timing: grant is combinational, in the same cycle as the request. At most one grant per cycle; never two.
- RAM drive: the winner drives ram_addr and ram_di. Write: ram_we=4'hF, ram_en=0. Read: ram_we=0, ram_en=1. No grant: ram_we=0, ram_en=0, ram_addr/ram_di=0.
- Arbitration, single requester: a lone request is always granted (no idle bubble).
- Arbitration, both requesting with eng_busy=1: eng wins, unless wait_cnt==STARVE_LIM, in which case cfg wins (forced grant).
- Arbitration, both requesting with eng_busy=0: the rr_ptr side wins. rr_ptr toggles to the other side after any conflicted grant.
- wait_cnt (8-bit): increments, saturating at STARVE_LIM, each cycle cfg_req=1 && cfg_gnt=0 && eng_busy=1. Clears on cfg_gnt, on cfg_req=0, or on eng_busy=0.
- starve_o: registered; 1 in the cycle after a forced cfg grant, else 0.
- Read return: tags rd_cfg and rd_eng are registered from (gnt && !we). In cycle N+1 after a granted read, the owning side's rvalid=1 and its rdata=ram_do. The other side's rdata=0.
- Write response: none. A write is complete at grant.
- Response handshake: no backpressure on read responses; requesters must accept rvalid.
- Back-to-back grants: throughput 1 access/cycle. Back-to-back reads from alternating sides return in grant order with exact 1-cycle latency.
- Request changes: a request changing its address or we while ungranted is legal; the value sampled at grant is used.
- Reset mid-read: a read granted in the cycle before reset asserts produces no rvalid.
- eng_busy changes: a change takes effect in the same cycle's arbitration.

Optional Feature:
- Macro: FIR_ARB_PERF_EN.
- Defined: three 16-bit saturating (hold at 16'hFFFF) counters, cleared only by reset.
  - cfg_gnt_cnt: +1 per cfg_gnt.
  - eng_gnt_cnt: +1 per eng_gnt.
  - conflict_cnt: +1 per cycle with cfg_req && eng_req.
- Not defined: the counter ports still exist, are tied to 0, and no counter flops are synthesized.
- Arbitration is identical either way.

Test Plan:
- Reset, then cfg write addr 0x040 data 0x0000_0015 alone -> cfg_gnt=1 same cycle, ram_we=4'hF, ram_addr=0x040, ram_di=0x15. Then cfg read 0x040 -> cfg_rvalid=1 next cycle, cfg_rdata=0x15, eng_rvalid=0.
- eng_busy=1, both requesting continuously, STARVE_LIM=8 -> eng granted 8 cycles, cfg granted on cycle 9, starve_o pulses on cycle 10, eng granted again on cycle 10.
- eng_busy=0, both requesting reads to 0x000 and 0x080 for 4 cycles -> grants alternate cfg,eng,cfg,eng. rvalid alternates with 1-cycle lag and the correct data per side.
- Hold axis_rst_n=0 with both requests asserted -> no grants, ram_we=0, ram_en=0. Deassert reset during an in-flight read -> no spurious rvalid.
- Requests dropped (eng_busy=1, cfg waiting 5 cycles then deasserts) -> wait_cnt clears; a new cfg request waits a full 8 cycles again before its forced grant.
- With FIR_ARB_PERF_EN: 10 conflict cycles plus 3 lone eng accesses -> conflict_cnt=10, cfg_gnt_cnt+eng_gnt_cnt=13. Without the macro -> all counters read 0.
